// File: rtl/fsm_pkg.sv
// Shared state encoding and length helper for the serial pattern generator.
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_PAR  = 2'd3
  } state_t;

  // A length of zero or one beyond the pattern width selects the full width.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Load handshake and serial output bundle of the serial pattern generator.
interface serial_pattern_gen_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [CW-1:0]    len;
  logic             a_out;
  logic             a_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, pattern, len,
    input  load_ready, a_out, a_valid, busy, done
  );

  modport slave (
    input  load_valid, pattern, len,
    output load_ready, a_out, a_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_gen_down_counter.sv
// Loadable down counter that saturates at zero; used for bit and gap counting.
module down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  assign zero_c = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero_c) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// Shifts a loaded pattern out MSB-first, then holds the line idle for GAP cycles.
// Optional trailing even-parity bit enabled by SERIAL_PATTERN_GEN_PARITY_EN.
module serial_pattern_gen
  import fsm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input logic              clk,
  input logic              reset_n,
  serial_pattern_gen_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam state_t AFTER_FRAME = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bitcnt, len_eff_c;
  logic             bit_zero_c, bit_last_c, bit_en_c;
  logic [GW-1:0]    gapcnt;
  logic             gap_zero_c, gap_last_c, gap_en_c, gap_load_c;
  logic             handshake_c;
  logic             a_out_q, a_valid_q, busy_q, done_q, last_q;
  logic             a_out_nxt, a_valid_nxt, last_nxt;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  logic             par_q, par_nxt;
`endif

  assign handshake_c = bus.load_valid && (state == ST_IDLE);
  assign len_eff_c   = CW'(eff_len(32'(bus.len), WIDTH));

  // Counters stop one short of zero so the last cycle of each phase is cnt==1.
  assign bit_last_c = (bitcnt == CW'(1)) || bit_zero_c;
  assign bit_en_c   = (state == ST_SEND) && !bit_last_c;
  assign gap_last_c = (gapcnt == GW'(1)) || gap_zero_c;
  assign gap_en_c   = (state == ST_GAP) && !gap_last_c;
  assign gap_load_c = (state_nxt == ST_GAP) && (state != ST_GAP);

  down_counter #(.W(CW)) u_bitcnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (handshake_c),
    .load_val (len_eff_c),
    .en       (bit_en_c),
    .cnt      (bitcnt),
    .zero_c   (bit_zero_c)
  );

  down_counter #(.W(GW)) u_gapcnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load_c),
    .load_val (GW'(GAP)),
    .en       (gap_en_c),
    .cnt      (gapcnt),
    .zero_c   (gap_zero_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    a_out_nxt   = 1'b0;
    a_valid_nxt = 1'b0;
    last_nxt    = 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    par_nxt     = par_q;
`endif
    case (state)
      ST_IDLE: begin
        if (handshake_c) begin
          state_nxt = ST_SEND;
          shreg_nxt = bus.pattern;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
          par_nxt   = 1'b0;
`endif
        end
      end
      ST_SEND: begin
        a_out_nxt   = shreg[WIDTH-1];
        a_valid_nxt = 1'b1;
        shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        par_nxt     = par_q ^ shreg[WIDTH-1];
        if (bit_last_c) begin
          state_nxt = ST_PAR;
        end
`else
        if (bit_last_c) begin
          state_nxt = AFTER_FRAME;
          last_nxt  = 1'b1;
        end
`endif
      end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      ST_PAR: begin
        a_out_nxt   = par_q;
        a_valid_nxt = 1'b1;
        last_nxt    = 1'b1;
        state_nxt   = AFTER_FRAME;
      end
`endif
      ST_GAP: begin
        if (gap_last_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // done trails the flag raised alongside the final frame bit by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      a_out_q   <= 1'b0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      shreg     <= shreg_nxt;
      a_out_q   <= a_out_nxt;
      a_valid_q <= a_valid_nxt;
      busy_q    <= (state_nxt != ST_IDLE);
      last_q    <= last_nxt;
      done_q    <= last_q;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

  assign bus.load_ready = (state == ST_IDLE);
  assign bus.a_out      = a_out_q;
  assign bus.a_valid    = a_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed and randomized checks of serial_pattern_gen (GAP=2 and GAP=0 instances).
module tb_serial_pattern_gen;

  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_pattern_gen_if #(.WIDTH(WIDTH)) bus2 ();
  serial_pattern_gen_if #(.WIDTH(WIDTH)) bus0 ();

  serial_pattern_gen #(.WIDTH(WIDTH), .GAP(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  serial_pattern_gen #(.WIDTH(WIDTH), .GAP(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int eff(input logic [3:0] l);
    return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
  endfunction

  task automatic drive(input bit sel, input logic lv, input logic [7:0] pat, input logic [3:0] ln);
    if (sel) begin
      bus0.load_valid = lv; bus0.pattern = pat; bus0.len = ln;
    end else begin
      bus2.load_valid = lv; bus2.pattern = pat; bus2.len = ln;
    end
  endtask

  task automatic obs(input bit sel, output logic v, output logic o, output logic d,
                     output logic b, output logic r);
    if (sel) begin
      v = bus0.a_valid; o = bus0.a_out; d = bus0.done; b = bus0.busy; r = bus0.load_ready;
    end else begin
      v = bus2.a_valid; o = bus2.a_out; d = bus2.done; b = bus2.busy; r = bus2.load_ready;
    end
  endtask

  // Frame model: bits on cycles 1..L, parity on L+1, done at F+1, busy for F+GAP cycles.
  task automatic run_frame(input bit sel, input logic [7:0] pat, input logic [3:0] ln,
                           input int stop_k, output int busy_cycles);
    int L, F, g, ones;
    logic v, o, d, b, r, ev, eo, ed, eb;
    logic [7:0] p;
    p = pat; L = eff(ln); F = L + PAR; g = sel ? 0 : 2;
    ones = 0;
    for (int i = 0; i < L; i++) ones += int'(p[7-i]);
    obs(sel, v, o, d, b, r);
    check("ready_before_load", 32'(r), 32'(1));
    drive(sel, 1'b1, pat, ln);
    @(posedge clk);
    @(negedge clk);
    busy_cycles = 0;
    for (int k = 0; k <= F + g + 1; k++) begin
      if (stop_k >= 0 && k > stop_k) break;
      if (k > 0) @(negedge clk);
      obs(sel, v, o, d, b, r);
      ev = (k >= 1 && k <= F);
      if (k >= 1 && k <= L) eo = p[8-k];
      else if (PAR == 1 && k == L + 1) eo = ones[0];
      else eo = 1'b0;
      ed = (k == F + 1);
      eb = (k < F + g);
      check($sformatf("a_valid k=%0d pat=%h len=%0d", k, pat, ln), 32'(v), 32'(ev));
      if (ev) check($sformatf("a_out k=%0d pat=%h len=%0d", k, pat, ln), 32'(o), 32'(eo));
      check($sformatf("done k=%0d", k), 32'(d), 32'(ed));
      check($sformatf("busy k=%0d", k), 32'(b), 32'(eb));
      check($sformatf("load_ready k=%0d", k), 32'(r), 32'(!eb));
      busy_cycles += int'(b);
      drive(sel, 1'b0, 8'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, F, n, last1, first2, idle;
    logic av [0:63];
    logic ao [0:63];
    logic ev, eo;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    repeat (2) @(negedge clk);
    check("reset a_out", 32'(bus2.a_out), 32'(0));
    check("reset a_valid", 32'(bus2.a_valid), 32'(0));
    check("reset busy", 32'(bus2.busy), 32'(0));
    check("reset done", 32'(bus2.done), 32'(0));
    check("reset load_ready", 32'(bus2.load_ready), 32'(1));
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(1'b0, 8'b1011_0010, 4'd8, -1, bc);
    check("busy_cycles len8", 32'(bc), 32'(8 + PAR + 2));
    run_frame(1'b0, 8'b1100_0000, 4'd3, -1, bc);
    check("busy_cycles len3", 32'(bc), 32'(3 + PAR + 2));
    run_frame(1'b0, 8'h96, 4'd0, -1, bc);
    check("busy_cycles len0", 32'(bc), 32'(8 + PAR + 2));
    run_frame(1'b0, 8'h3C, 4'd15, -1, bc);
    check("busy_cycles len15", 32'(bc), 32'(8 + PAR + 2));
    run_frame(1'b0, 8'b1011_0000, 4'd4, -1, bc);
    run_frame(1'b0, 8'b1000_0000, 4'd1, -1, bc);
    run_frame(1'b1, 8'hC5, 4'd5, -1, bc);

    // Back-to-back on the GAP=0 instance with load_valid held high.
    F = 8 + PAR;
    n = 2 * F + 6;
    drive(1'b1, 1'b1, 8'hFF, 4'd8);
    @(posedge clk);
    @(negedge clk);
    bus0.pattern = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      av[k] = bus0.a_valid;
      ao[k] = bus0.a_out;
      if (k == F + 1) bus0.load_valid = 1'b0;
    end
    last1 = -1; first2 = -1; idle = 0;
    for (int k = 0; k < n; k++) begin
      ev = ((k >= 1) && (k <= F)) || ((k >= F + 2) && (k <= 2 * F + 1));
      eo = (k >= 1) && (k <= 8);
      check($sformatf("b2b a_valid k=%0d", k), 32'(av[k]), 32'(ev));
      if (ev) check($sformatf("b2b a_out k=%0d", k), 32'(ao[k]), 32'(eo));
      if (av[k] && first2 < 0 && (last1 < 0 || k == last1 + 1)) last1 = k;
      else if (av[k] && first2 < 0) first2 = k;
      else if (!av[k] && last1 >= 0 && first2 < 0) idle++;
    end
    check("b2b first2-last1", 32'(first2 - last1), 32'(2));
    check("b2b idle cycles", 32'(idle), 32'(1));

    // Reset during the third bit of a frame.
    run_frame(1'b0, 8'hA5, 4'd8, 3, bc);
    #2 reset_n = 1'b0;
    #1;
    check("async a_out", 32'(bus2.a_out), 32'(0));
    check("async a_valid", 32'(bus2.a_valid), 32'(0));
    check("async busy", 32'(bus2.busy), 32'(0));
    check("async done", 32'(bus2.done), 32'(0));
    check("async load_ready", 32'(bus2.load_ready), 32'(1));
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("post_reset done k=%0d", k), 32'(bus2.done), 32'(0));
      check($sformatf("post_reset a_valid k=%0d", k), 32'(bus2.a_valid), 32'(0));
    end
    run_frame(1'b0, 8'hA5, 4'd8, -1, bc);

    for (int i = 0; i < 16; i++) begin
      run_frame(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), -1, bc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
